// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: reprograms the FIR filter coefficient RAM.
// The host streams NUM_TAPS coefficients over a valid/ready handshake. The
// loader raises the filter's update flag, waits SETTLE cycles, writes each
// accepted coefficient to RAM addresses 0..NUM_TAPS-1 with a one-cycle
// active-low strobe, waits SETTLE more cycles and drops the flag again.
//
// Handshake (iCoeffValid / oCoeffReady): a coefficient is transferred on
// every rising edge where both are high. oCoeffReady is registered, is high
// only in WRITE, and never depends combinationally on iCoeffValid. Once it
// is high it stays high until the last coefficient is accepted. iCoeff is
// only sampled on a transfer edge. iCoeffValid may be dropped at any time,
// which stalls the load.
//
// Load timeline with iCoeffValid held high. e0 is the edge that samples
// iLoadStart.
//   e0                  : ENTER, flag = 1, busy = 1
//   e0+SETTLE           : WRITE, ready still low
//   e0+SETTLE+1         : ready rises
//   next NUM_TAPS edges : one transfer per edge, one write strobe per cycle
//   last transfer edge  : ready drops, DRAIN (last strobe is still driven)
//   +1                  : strobe released, EXIT
//   +SETTLE             : IDLE, flag = 0, done pulse
//
// oFsmState exposes the current state for observation.

module fir_coeff_loader #(
    parameter int NUM_TAPS = 40,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16,
    parameter int SETTLE   = 2
) (
    input  logic              iClk12M,
    input  logic              iRsn,
    input  logic              iLoadStart,
    input  logic              iAbort,
    input  logic              iCoeffValid,
    input  logic [DATA_W-1:0] iCoeff,
    output logic              oCoeffReady,
    output logic              oCoeffUpdateFlag,
    output logic              oCsnRam,
    output logic              oWrnRam,
    output logic [ADDR_W-1:0] oAddrRam,
    output logic [DATA_W-1:0] oWtDtRam,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr,
    output logic [2:0]        oFsmState
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTER = 3'd1,
        WRITE = 3'd2,
        DRAIN = 3'd3,
        EXIT  = 3'd4
    } loadStateT;

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_TAPS - 1);
    localparam logic [3:0]        SETTLE_CNT = 4'(SETTLE);

    // Registered state and outputs
    loadStateT         state;
    logic [3:0]        settleCnt;
    logic [ADDR_W-1:0] tapIdx;
    logic              flagReg;
    logic              csnReg;
    logic              wrnReg;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] dataReg;
    logic              readyReg;
    logic              doneReg;
    logic              errReg;

    // Next-state values
    loadStateT         stateNext;
    logic [3:0]        settleNext;
    logic [ADDR_W-1:0] tapNext;
    logic              flagNext;
    logic              csnNext;
    logic              wrnNext;
    logic [ADDR_W-1:0] addrNext;
    logic [DATA_W-1:0] dataNext;
    logic              readyNext;
    logic              doneNext;
    logic              errNext;

    logic              handshake;

    // readyReg is only ever high in WRITE, so this needs no state qualifier.
    assign handshake = iCoeffValid & readyReg;

    // State register: every output is a flop, reset drops a load silently.
    always_ff @(posedge iClk12M) begin
        if (!iRsn) begin
            state     <= IDLE;
            settleCnt <= 4'd0;
            tapIdx    <= '0;
            flagReg   <= 1'b0;
            csnReg    <= 1'b1;
            wrnReg    <= 1'b1;
            addrReg   <= '0;
            dataReg   <= '0;
            readyReg  <= 1'b0;
            doneReg   <= 1'b0;
            errReg    <= 1'b0;
        end else begin
            state     <= stateNext;
            settleCnt <= settleNext;
            tapIdx    <= tapNext;
            flagReg   <= flagNext;
            csnReg    <= csnNext;
            wrnReg    <= wrnNext;
            addrReg   <= addrNext;
            dataReg   <= dataNext;
            readyReg  <= readyNext;
            doneReg   <= doneNext;
            errReg    <= errNext;
        end
    end

    // Next-state and output decode; abort overrides everything outside IDLE.
    always_comb begin
        stateNext  = state;
        settleNext = settleCnt;
        tapNext    = tapIdx;
        flagNext   = flagReg;
        csnNext    = 1'b1;
        wrnNext    = 1'b1;
        addrNext   = addrReg;
        dataNext   = dataReg;
        readyNext  = 1'b0;
        doneNext   = 1'b0;
        errNext    = 1'b0;

        case (state)
            IDLE: begin
                flagNext = 1'b0;
                tapNext  = '0;
                if (iLoadStart && !iAbort) begin
                    stateNext  = ENTER;
                    flagNext   = 1'b1;
                    settleNext = SETTLE_CNT;
                end
            end

            ENTER: begin
                flagNext = 1'b1;
                if (settleCnt <= 4'd1) begin
                    stateNext  = WRITE;
                    settleNext = 4'd0;
                end else begin
                    settleNext = settleCnt - 4'd1;
                end
            end

            WRITE: begin
                flagNext  = 1'b1;
                readyNext = 1'b1;
                if (handshake) begin
                    csnNext  = 1'b0;
                    wrnNext  = 1'b0;
                    addrNext = tapIdx;
                    dataNext = iCoeff;
                    if (tapIdx == LAST_IDX) begin
                        // The last write is driven while ready falls.
                        stateNext = DRAIN;
                        readyNext = 1'b0;
                        tapNext   = '0;
                    end else begin
                        tapNext = tapIdx + 1'b1;
                    end
                end
            end

            DRAIN: begin
                flagNext   = 1'b1;
                stateNext  = EXIT;
                settleNext = SETTLE_CNT;
            end

            EXIT: begin
                flagNext = 1'b1;
                if (settleCnt <= 4'd1) begin
                    stateNext  = IDLE;
                    settleNext = 4'd0;
                    flagNext   = 1'b0;
                    doneNext   = 1'b1;
                end else begin
                    settleNext = settleCnt - 4'd1;
                end
            end

            default: begin
                stateNext  = IDLE;
                flagNext   = 1'b0;
                tapNext    = '0;
                settleNext = 4'd0;
            end
        endcase

        // A transfer coincident with abort is discarded. A strobe that is
        // already on the RAM pins in this cycle is left to complete.
        if (state != IDLE && iAbort) begin
            stateNext  = IDLE;
            settleNext = 4'd0;
            tapNext    = '0;
            flagNext   = 1'b0;
            csnNext    = 1'b1;
            wrnNext    = 1'b1;
            addrNext   = addrReg;
            dataNext   = dataReg;
            readyNext  = 1'b0;
            doneNext   = 1'b0;
            errNext    = 1'b1;
        end
    end

    assign oCoeffReady      = readyReg;
    assign oCoeffUpdateFlag = flagReg;
    assign oCsnRam          = csnReg;
    assign oWrnRam          = wrnReg;
    assign oAddrRam         = addrReg;
    assign oWtDtRam         = dataReg;
    assign oBusy            = (state != IDLE);
    assign oDone            = doneReg;
    assign oErr             = errReg;
    assign oFsmState        = state;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: reset, full, throttled, aborted,
// ignored-start and reset-in-EXIT loads, checked against hand-computed
// expectations.

module tb_fir_coeff_loader;

  localparam int NT = 40;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int WW = AW + DW;

  logic          clk;
  logic          iRsn;
  logic          iLoadStart;
  logic          iAbort;
  logic          iCoeffValid;
  logic [DW-1:0] iCoeff;
  logic          oCoeffReady;
  logic          oCoeffUpdateFlag;
  logic          oCsnRam;
  logic          oWrnRam;
  logic [AW-1:0] oAddrRam;
  logic [DW-1:0] oWtDtRam;
  logic          oBusy;
  logic          oDone;
  logic          oErr;
  logic [2:0]    oFsmState;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // scoreboard
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] got_q[$];
  int done_cnt = 0;
  int err_cnt = 0;
  int done_cyc = 0;
  int first_wr_cyc = 0;
  int last_wr_cyc = 0;
  int flag_fall_cyc = 0;
  int start_cyc = 0;
  logic prev_flag = 1'b0;

  fir_coeff_loader #(
    .NUM_TAPS(NT), .ADDR_W(AW), .DATA_W(DW), .SETTLE(2)
  ) dut (
    .iClk12M(clk),
    .iRsn(iRsn),
    .iLoadStart(iLoadStart),
    .iAbort(iAbort),
    .iCoeffValid(iCoeffValid),
    .iCoeff(iCoeff),
    .oCoeffReady(oCoeffReady),
    .oCoeffUpdateFlag(oCoeffUpdateFlag),
    .oCsnRam(oCsnRam),
    .oWrnRam(oWrnRam),
    .oAddrRam(oAddrRam),
    .oWtDtRam(oWtDtRam),
    .oBusy(oBusy),
    .oDone(oDone),
    .oErr(oErr),
    .oFsmState(oFsmState)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: capture RAM writes and pulses away from the active edge
  always @(negedge clk) begin
    if (iRsn && !oCsnRam && !oWrnRam) begin
      if (got_q.size() == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      got_q.push_back({oAddrRam, oWtDtRam});
    end
    if (oDone) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (oErr) err_cnt = err_cnt + 1;
    if (prev_flag && !oCoeffUpdateFlag) flag_fall_cyc = cyc;
    prev_flag = oCoeffUpdateFlag;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp_writes(input string tag);
    int n;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_write"}, 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  // driver: one load; mode 0 = valid always high, 1 = valid every other cycle
  task automatic do_load(input int mode, input logic [DW-1:0] base,
                         input int abort_at, input int start_at, input bit wait_done);
    int n;
    int guard;
    int done_before;
    int k;
    bit hs;
    bit ab;
    got_q.delete();
    exp_q.delete();
    n = 0;
    guard = 0;
    ab = 1'b0;
    start_cyc = cyc;
    iLoadStart = 1'b1;
    tick(1);
    iLoadStart = 1'b0;
    while (n < NT && guard < 400 && !ab) begin
      iCoeffValid = (mode == 0) || (guard % 2 == 0);
      iCoeff = base + DW'(n);
      iLoadStart = (n == start_at);
      @(negedge clk);
      hs = iCoeffValid && oCoeffReady;
      if (hs && n == abort_at) iAbort = 1'b1;
      @(posedge clk);
      #1;
      if (iAbort) ab = 1'b1;
      else if (hs) begin
        exp_q.push_back({AW'(n), base + DW'(n)});
        n++;
      end
      guard++;
    end
    iCoeffValid = 1'b0;
    iLoadStart = 1'b0;
    iAbort = 1'b0;
    chk("load_progress", 32'(guard < 400), 32'd1);
    if (wait_done) begin
      done_before = done_cnt;
      k = 0;
      while (done_cnt == done_before && k < 100) begin
        tick(1);
        k++;
      end
      chk("done_timeout", 32'(k < 100), 32'd1);
      tick(1);
    end
  endtask

  initial begin
    int d0;
    int e0;

    iRsn = 1'b0;
    iLoadStart = 1'b0;
    iAbort = 1'b0;
    iCoeffValid = 1'b0;
    iCoeff = '0;

    // reset with random inputs
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      iLoadStart = 1'($urandom_range(1, 0));
      iAbort = 1'($urandom_range(1, 0));
      iCoeffValid = 1'($urandom_range(1, 0));
      iCoeff = DW'($urandom_range(16'hffff, 0));
    end
    tick(1);
    chk("rst_flag", oCoeffUpdateFlag, 0);
    chk("rst_csn", oCsnRam, 1);
    chk("rst_wrn", oWrnRam, 1);
    chk("rst_ready", oCoeffReady, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_err", oErr, 0);
    chk("rst_addr", oAddrRam, 0);
    chk("rst_data", oWtDtRam, 0);
    iLoadStart = 1'b0;
    iAbort = 1'b0;
    iCoeffValid = 1'b0;
    iRsn = 1'b1;
    tick(2);
    done_cnt = 0;
    err_cnt = 0;

    // full load, valid always high
    iLoadStart = 1'b1;
    tick(1);
    chk("start_flag", oCoeffUpdateFlag, 1);
    chk("start_busy", oBusy, 1);
    chk("start_ready", oCoeffReady, 0);
    // abandon this one with reset so the timed load starts clean
    iLoadStart = 1'b0;
    iRsn = 1'b0;
    tick(1);
    iRsn = 1'b1;
    tick(1);
    d0 = done_cnt;
    e0 = err_cnt;
    do_load(0, 16'h1000, -1, -1, 1'b1);
    cmp_writes("full");
    chk("full_done_once", done_cnt - d0, 1);
    chk("full_no_err", err_cnt - e0, 0);
    chk("full_latency", done_cyc - start_cyc, 47);
    chk("full_first_wr", first_wr_cyc - start_cyc, 5);
    chk("full_last_wr", last_wr_cyc - start_cyc, 44);
    chk("full_flag_after", flag_fall_cyc - last_wr_cyc, 3);
    chk("full_idle_busy", oBusy, 0);
    chk("full_idle_flag", oCoeffUpdateFlag, 0);

    // throttled load
    d0 = done_cnt;
    e0 = err_cnt;
    do_load(1, 16'h2000, -1, -1, 1'b1);
    cmp_writes("thr");
    chk("thr_done_once", done_cnt - d0, 1);
    chk("thr_no_err", err_cnt - e0, 0);

    // abort coincident with the 18th handshake
    d0 = done_cnt;
    e0 = err_cnt;
    do_load(0, 16'h3000, 17, -1, 1'b0);
    chk("abt_flag", oCoeffUpdateFlag, 0);
    chk("abt_csn", oCsnRam, 1);
    chk("abt_err", oErr, 1);
    chk("abt_busy", oBusy, 0);
    chk("abt_ready", oCoeffReady, 0);
    tick(1);
    chk("abt_err_pulse", oErr, 0);
    tick(2);
    cmp_writes("abt");
    chk("abt_err_once", err_cnt - e0, 1);
    chk("abt_no_done", done_cnt - d0, 0);

    // new load after abort starts at address 0
    d0 = done_cnt;
    do_load(0, 16'h4000, -1, -1, 1'b1);
    cmp_writes("post_abt");
    chk("post_abt_done", done_cnt - d0, 1);

    // start with abort in IDLE is ignored
    d0 = done_cnt;
    e0 = err_cnt;
    iLoadStart = 1'b1;
    iAbort = 1'b1;
    tick(1);
    iLoadStart = 1'b0;
    iAbort = 1'b0;
    chk("sa_busy", oBusy, 0);
    chk("sa_flag", oCoeffUpdateFlag, 0);
    tick(1);
    chk("sa_no_err", err_cnt - e0, 0);
    chk("sa_no_done", done_cnt - d0, 0);

    // start pulsed during WRITE is ignored
    do_load(0, 16'h5000, -1, 5, 1'b1);
    cmp_writes("sw");
    chk("sw_done_once", done_cnt - d0, 1);
    tick(5);
    chk("sw_idle", oBusy, 0);
    chk("sw_no_extra_done", done_cnt - d0, 1);

    // reset during EXIT
    d0 = done_cnt;
    do_load(0, 16'h6000, -1, -1, 1'b0);
    tick(1);
    chk("rx_in_exit", oFsmState, 3'd4);
    chk("rx_flag_pre", oCoeffUpdateFlag, 1);
    iRsn = 1'b0;
    tick(1);
    chk("rx_flag", oCoeffUpdateFlag, 0);
    chk("rx_busy", oBusy, 0);
    chk("rx_done", oDone, 0);
    iRsn = 1'b1;
    tick(5);
    cmp_writes("rx");
    chk("rx_no_done", done_cnt - d0, 0);

    // following load behaves like the first full load
    d0 = done_cnt;
    e0 = err_cnt;
    do_load(0, 16'h1000, -1, -1, 1'b1);
    cmp_writes("rx_full");
    chk("rx_full_done", done_cnt - d0, 1);
    chk("rx_full_no_err", err_cnt - e0, 0);
    chk("rx_full_latency", done_cyc - start_cyc, 47);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
